// File: rtl/clk_meter_pkg.sv
// Shared definitions for the clock meter: FSM encoding and default parameter values.
package clk_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_t;

  localparam int unsigned NUM_PER_DEF = 8;
  localparam int unsigned CNT_W_DEF   = 24;
  localparam int unsigned TO_CYC_DEF  = 50_000_000;

endpackage

// File: rtl/sync_edge.sv
// Three-flop synchroniser for an asynchronous level plus rising-edge detect
// on the synchronised copy.
module sync_edge (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic async_in,
  output logic sig_s,
  output logic rise
);

  logic ff1;
  logic ff2;
  logic ff3;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ff1 <= 1'b0;
      ff2 <= 1'b0;
      ff3 <= 1'b0;
    end else begin
      ff1 <= async_in;
      ff2 <= ff1;
      ff3 <= ff2;
    end
  end

  assign sig_s = ff2;
  assign rise  = ff2 & ~ff3;

endmodule

// File: rtl/clk_meter.sv
// Measures NUM_PER periods of sig_in against sys_clk, reporting total and high
// cycle counts, with a watchdog that aborts when sig_in stops toggling.
module clk_meter
  import clk_meter_pkg::*;
#(
  parameter int unsigned NUM_PER = NUM_PER_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TO_CYC  = TO_CYC_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             sig_in,
  output logic             busy,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             meas_valid,
  output logic             timeout
);

  localparam int unsigned WD_W = $clog2(TO_CYC);
  localparam int unsigned EC_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TO_CYC - 1);
  localparam logic [EC_W-1:0]  EC_LAST = EC_W'(NUM_PER - 1);

  logic sig_s;
  logic rise;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] acc_tot_q, acc_tot_d;
  logic [CNT_W-1:0] acc_high_q, acc_high_d;
  logic [EC_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             busy_d;
  logic             meas_valid_d;
  logic             timeout_d;
  logic [CNT_W-1:0] period_d;
  logic [CNT_W-1:0] high_d;

  sync_edge u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .async_in  (sig_in),
    .sig_s     (sig_s),
    .rise      (rise)
  );

  // Accumulators stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic inc);
    sat_add = (inc && (a != CNT_MAX)) ? a + CNT_W'(1) : a;
  endfunction

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      acc_tot_q  <= '0;
      acc_high_q <= '0;
      edge_cnt_q <= '0;
      wdog_q     <= '0;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      period_cnt <= '0;
      high_cnt   <= '0;
    end else begin
      state_q    <= state_d;
      acc_tot_q  <= acc_tot_d;
      acc_high_q <= acc_high_d;
      edge_cnt_q <= edge_cnt_d;
      wdog_q     <= wdog_d;
      busy       <= busy_d;
      meas_valid <= meas_valid_d;
      timeout    <= timeout_d;
      period_cnt <= period_d;
      high_cnt   <= high_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_tot_d    = acc_tot_q;
    acc_high_d   = acc_high_q;
    edge_cnt_d   = edge_cnt_q;
    wdog_d       = wdog_q;
    busy_d       = busy;
    meas_valid_d = 1'b0;
    timeout_d    = 1'b0;
    period_d     = period_cnt;
    high_d       = high_cnt;

    case (state_q)
      IDLE: begin
        acc_tot_d  = '0;
        acc_high_d = '0;
        edge_cnt_d = '0;
        wdog_d     = '0;
        busy_d     = start;
        if (start) begin
          state_d = ARM;
        end
      end

      ARM: begin
        if (rise) begin
          state_d    = MEAS;
          acc_tot_d  = CNT_W'(1);
          acc_high_d = CNT_W'(1);
          edge_cnt_d = '0;
          wdog_d     = '0;
        end else if (wdog_q == WD_LAST) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end

      MEAS: begin
        if (rise) begin
          edge_cnt_d = edge_cnt_q + EC_W'(1);
          wdog_d     = '0;
          // The terminating edge opens the next period, so it is not counted.
          if (edge_cnt_q == EC_LAST) begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            meas_valid_d = 1'b1;
            period_d     = acc_tot_q;
            high_d       = acc_high_q;
          end else begin
            acc_tot_d  = sat_add(acc_tot_q, 1'b1);
            acc_high_d = sat_add(acc_high_q, 1'b1);
          end
        end else if (wdog_q == WD_LAST) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          acc_tot_d  = sat_add(acc_tot_q, 1'b1);
          acc_high_d = sat_add(acc_high_q, sig_s);
          wdog_d     = wdog_q + WD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule
